// File: rtl/pu_or1k_ctrl_spr_access_pkg.sv
// Shared types and constants for the ctrl-stage SPR access responder.
// Package name is pu_or1k_spr_pkg; the file is named after the block it serves.
package pu_or1k_spr_pkg;

  // Access FSM state encoding
  typedef enum logic [1:0] {
    SPR_IDLE = 2'd0,
    SPR_BUS  = 2'd1,
    SPR_ACK  = 2'd2,
    SPR_HOLD = 2'd3
  } spr_state_t;

  localparam int SPR_ADDR_WIDTH = 16;

  // SPR address layout: group in [15:11], index in [10:0]
  localparam int SPR_GROUP_MSB = 15;
  localparam int SPR_GROUP_LSB = 11;
  localparam int SPR_INDEX_MSB = 10;
  localparam int SPR_INDEX_LSB = 0;

  function automatic logic [SPR_GROUP_MSB-SPR_GROUP_LSB:0] spr_group(
    input logic [SPR_ADDR_WIDTH-1:0] adr);
    return adr[SPR_GROUP_MSB:SPR_GROUP_LSB];
  endfunction

  function automatic logic [SPR_INDEX_MSB-SPR_INDEX_LSB:0] spr_index(
    input logic [SPR_ADDR_WIDTH-1:0] adr);
    return adr[SPR_INDEX_MSB:SPR_INDEX_LSB];
  endfunction

endpackage

// File: rtl/pu_or1k_ctrl_spr_access_if.sv
// SPR bus bundle between the ctrl-stage responder (master) and the SPR fabric (slave).
interface pu_or1k_ctrl_spr_access_if #(
  parameter int OPTION_OPERAND_WIDTH  = 32,
  parameter int OPTION_SPR_ADDR_WIDTH = 16
);
  logic                             spr_bus_stb_o;
  logic                             spr_bus_we_o;
  logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_adr_o;
  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o;
  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i;
  logic                             spr_bus_ack_i;

  modport master (
    output spr_bus_stb_o, spr_bus_we_o, spr_bus_adr_o, spr_bus_dat_o,
    input  spr_bus_dat_i, spr_bus_ack_i
  );

  modport slave (
    input  spr_bus_stb_o, spr_bus_we_o, spr_bus_adr_o, spr_bus_dat_o,
    output spr_bus_dat_i, spr_bus_ack_i
  );
endinterface

// File: rtl/pu_or1k_ctrl_spr_access_timer.sv
// Bus-wait timeout counter for the SPR responder.
// Only present when PU_OR1K_SPR_TIMEOUT_EN is defined.
`ifdef PU_OR1K_SPR_TIMEOUT_EN
module pu_or1k_ctrl_spr_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // Count enabled cycles; clear outside the wait window
  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  // Fires on the LIMIT-th enabled cycle, so the caller leaves BUS after LIMIT cycles
  assign expire = en && (cnt == CW'(LIMIT - 1));
endmodule
`endif

// File: rtl/pu_or1k_ctrl_spr_access.sv
// Ctrl-stage SPR access responder: runs l.mfspr/l.mtspr on the SPR bus and
// returns a one-cycle ack that releases the ctrl stall.
// Optional bus timeout: define PU_OR1K_SPR_TIMEOUT_EN.
module pu_or1k_ctrl_spr_access
  import pu_or1k_spr_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH  = 32,
  parameter int OPTION_SPR_ADDR_WIDTH = SPR_ADDR_WIDTH,
  parameter int OPTION_SPR_TIMEOUT    = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_ctrl_i,
  input  logic                            pipeline_flush_i,
  input  logic                            ctrl_op_mfspr_i,
  input  logic                            ctrl_op_mtspr_i,
  input  logic                            ctrl_except_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_spr_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] ctrl_rfb_i,
  output logic                            ctrl_mfspr_ack_o,
  output logic                            ctrl_mtspr_ack_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] ctrl_mfspr_dat_o,
  output logic                            spr_timeout_o,
  pu_or1k_ctrl_spr_access_if.master       spr_bus
);

  localparam logic [1:0] IDLE = SPR_IDLE;
  localparam logic [1:0] BUS  = SPR_BUS;
  localparam logic [1:0] ACK  = SPR_ACK;
  localparam logic [1:0] HOLD = SPR_HOLD;

  logic [1:0]                       state, state_nxt;
  logic                             we_q;
  logic [OPTION_SPR_ADDR_WIDTH-1:0] adr_q;
  logic [OPTION_OPERAND_WIDTH-1:0]  wdat_q;
  logic [OPTION_OPERAND_WIDTH-1:0]  rdat_q;
  logic                             start;
  logic                             expire;
  logic                             done;

  // Upper ALU-result bits above the SPR address are not part of the access
  logic unused_adr_hi;
  assign unused_adr_hi = ^ctrl_spr_adr_i[OPTION_OPERAND_WIDTH-1:OPTION_SPR_ADDR_WIDTH];

  assign start = (ctrl_op_mfspr_i | ctrl_op_mtspr_i) & ~ctrl_except_i & ~pipeline_flush_i;
  // Flush in BUS beats a same-cycle ack: the instruction is gone
  assign done  = (state == BUS) & ~pipeline_flush_i & (spr_bus.spr_bus_ack_i | expire);

`ifdef PU_OR1K_SPR_TIMEOUT_EN
  logic timeout_q;

  pu_or1k_ctrl_spr_timer #(.LIMIT(OPTION_SPR_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != BUS),
    .en     (state == BUS),
    .expire (expire)
  );

  // Sticky forced-completion flag, cleared when the next access starts
  always_ff @(posedge clk) begin
    if (rst)
      timeout_q <= 1'b0;
    else if (state == IDLE && start)
      timeout_q <= 1'b0;
    else if (done && !spr_bus.spr_bus_ack_i)
      timeout_q <= 1'b1;
  end

  assign spr_timeout_o = timeout_q;
`else
  localparam int unused_timeout = OPTION_SPR_TIMEOUT;
  assign expire        = 1'b0;
  assign spr_timeout_o = 1'b0;
`endif

  // Next-state: HOLD keeps a stalled instruction from issuing a second access
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUS;
      BUS: begin
        if (pipeline_flush_i) state_nxt = IDLE;
        else if (done)        state_nxt = ACK;
      end
      ACK:  state_nxt = (padv_ctrl_i || pipeline_flush_i) ? IDLE : HOLD;
      HOLD: if (padv_ctrl_i || pipeline_flush_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, request latch and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      adr_q  <= '0;
      wdat_q <= '0;
      rdat_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        // mtspr wins if both op bits are (illegally) set
        we_q   <= ctrl_op_mtspr_i;
        adr_q  <= ctrl_spr_adr_i[OPTION_SPR_ADDR_WIDTH-1:0];
        wdat_q <= ctrl_rfb_i;
      end
      // A forced (timed-out) read returns zero
      if (done && !we_q)
        rdat_q <= spr_bus.spr_bus_ack_i ? spr_bus.spr_bus_dat_i : '0;
    end
  end

  assign spr_bus.spr_bus_stb_o = (state == BUS);
  assign spr_bus.spr_bus_we_o  = (state == BUS) & we_q;
  assign spr_bus.spr_bus_adr_o = adr_q;
  assign spr_bus.spr_bus_dat_o = wdat_q;

  assign ctrl_mfspr_ack_o = (state == ACK) & ~we_q;
  assign ctrl_mtspr_ack_o = (state == ACK) &  we_q;
  assign ctrl_mfspr_dat_o = rdat_q;

endmodule

// File: tb/tb_pu_or1k_ctrl_spr_access.sv
// Scoreboard bench for pu_or1k_ctrl_spr_access: directed stimulus pushes the
// expected ctrl acks, a negedge monitor pops and compares each ack it sees.
module tb_pu_or1k_ctrl_spr_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        padv, flush, op_mf, op_mt, except;
  logic [31:0] spr_adr, rfb;
  logic        mf_ack, mt_ack, tmo;
  logic [31:0] mf_dat;

  pu_or1k_ctrl_spr_access_if #(.OPTION_OPERAND_WIDTH(32), .OPTION_SPR_ADDR_WIDTH(16)) bus ();

  pu_or1k_ctrl_spr_access #(
    .OPTION_OPERAND_WIDTH  (32),
    .OPTION_SPR_ADDR_WIDTH (16),
    .OPTION_SPR_TIMEOUT    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .padv_ctrl_i      (padv),
    .pipeline_flush_i (flush),
    .ctrl_op_mfspr_i  (op_mf),
    .ctrl_op_mtspr_i  (op_mt),
    .ctrl_except_i    (except),
    .ctrl_spr_adr_i   (spr_adr),
    .ctrl_rfb_i       (rfb),
    .ctrl_mfspr_ack_o (mf_ack),
    .ctrl_mtspr_ack_o (mt_ack),
    .ctrl_mfspr_dat_o (mf_dat),
    .spr_timeout_o    (tmo),
    .spr_bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mt;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   ack_cnt  = 0;
  int   stb_cyc  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every ctrl ack must match the oldest expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.spr_bus_stb_o === 1'b1) stb_cyc++;
      if (mf_ack === 1'b1 || mt_ack === 1'b1) begin
        ack_cnt++;
        if (mf_ack === 1'b1 && mt_ack === 1'b1)
          chk("both_acks", 32'(mf_ack & mt_ack), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ack_type", 32'(mt_ack), 32'(e.mt));
          if (!e.mt) chk("mfspr_dat", mf_dat, e.dat);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; padv = 1'b0; flush = 1'b0; op_mf = 1'b0; op_mt = 1'b0; except = 1'b0;
    spr_adr = '0; rfb = '0;
    bus.spr_bus_ack_i = 1'b0; bus.spr_bus_dat_i = '0;

    // Reset state
    tick(); tick(); smp();
    chk("rst_stb",    32'(bus.spr_bus_stb_o), 32'd0);
    chk("rst_we",     32'(bus.spr_bus_we_o),  32'd0);
    chk("rst_adr",    32'(bus.spr_bus_adr_o), 32'd0);
    chk("rst_dat",    bus.spr_bus_dat_o,      32'd0);
    chk("rst_mfack",  32'(mf_ack),            32'd0);
    chk("rst_mtack",  32'(mt_ack),            32'd0);
    chk("rst_mfdat",  mf_dat,                 32'd0);
    chk("rst_tmo",    32'(tmo),               32'd0);
    tick(); rst = 1'b0;
    tick();

    // mtspr, bus ack on 3rd stb cycle
    stb_cyc = 0; ack_cnt = 0;
    op_mt = 1'b1; spr_adr = 32'h0000_2801; rfb = 32'hDEAD_BEEF;
    exp_q.push_back('{mt: 1'b1, dat: 32'h0});
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 3) bus.spr_bus_ack_i = 1'b1;
      smp();
      chk("t1_stb", 32'(bus.spr_bus_stb_o), 32'd1);
      chk("t1_we",  32'(bus.spr_bus_we_o),  32'd1);
      chk("t1_adr", 32'(bus.spr_bus_adr_o), 32'h2801);
      chk("t1_dat", bus.spr_bus_dat_o,      32'hDEAD_BEEF);
    end
    tick(); bus.spr_bus_ack_i = 1'b0; padv = 1'b1; smp();
    chk("t1_mtack",    32'(mt_ack),            32'd1);
    chk("t1_stb_drop", 32'(bus.spr_bus_stb_o), 32'd0);
    tick(); op_mt = 1'b0; padv = 1'b0; smp();
    chk("t1_pulse",    32'(mt_ack), 32'd0);
    chk("t1_stb_cyc",  32'(stb_cyc), 32'd3);
    chk("t1_ack_cnt",  32'(ack_cnt), 32'd1);

    // mfspr, zero-wait bus
    tick(); op_mf = 1'b1; spr_adr = 32'h0000_0011;
    exp_q.push_back('{mt: 1'b0, dat: 32'h1234_5678});
    tick(); bus.spr_bus_ack_i = 1'b1; bus.spr_bus_dat_i = 32'h1234_5678; smp();
    chk("t2_stb", 32'(bus.spr_bus_stb_o), 32'd1);
    chk("t2_we",  32'(bus.spr_bus_we_o),  32'd0);
    tick(); bus.spr_bus_ack_i = 1'b0; bus.spr_bus_dat_i = '0; padv = 1'b1; smp();
    chk("t2_mfack_lat", 32'(mf_ack), 32'd1);
    chk("t2_mfdat",     mf_dat,      32'h1234_5678);
    tick(); op_mf = 1'b0; padv = 1'b0; smp();
    chk("t2_pulse",     32'(mf_ack), 32'd0);
    chk("t2_hold_dat",  mf_dat,      32'h1234_5678);

    // mfspr flushed in 2nd BUS cycle, late ack ignored
    stb_cyc = 0; ack_cnt = 0;
    tick(); op_mf = 1'b1; spr_adr = 32'h0000_0022;
    tick(); smp();
    chk("t3_bus1", 32'(bus.spr_bus_stb_o), 32'd1);
    tick(); flush = 1'b1; smp();
    chk("t3_bus2", 32'(bus.spr_bus_stb_o), 32'd1);
    tick(); flush = 1'b0; op_mf = 1'b0;
    bus.spr_bus_ack_i = 1'b1; bus.spr_bus_dat_i = 32'hAAAA_5555; smp();
    chk("t3_stb_drop", 32'(bus.spr_bus_stb_o), 32'd0);
    tick(); bus.spr_bus_ack_i = 1'b0; bus.spr_bus_dat_i = '0; smp();
    chk("t3_mfdat",    mf_dat,           32'h1234_5678);
    chk("t3_stb_cyc",  32'(stb_cyc),     32'd2);
    chk("t3_ack_cnt",  32'(ack_cnt),     32'd0);

    // ack with padv low for 4 cycles, op held: single access
    stb_cyc = 0; ack_cnt = 0;
    tick(); op_mt = 1'b1; spr_adr = 32'h0000_0033; rfb = 32'h0BAD_F00D;
    exp_q.push_back('{mt: 1'b1, dat: 32'h0});
    tick(); bus.spr_bus_ack_i = 1'b1;
    tick(); bus.spr_bus_ack_i = 1'b0; smp();
    chk("t4_mtack", 32'(mt_ack), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick(); smp();
      chk("t4_hold_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    end
    tick(); padv = 1'b1; smp();
    chk("t4_hold_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    tick(); padv = 1'b0; op_mt = 1'b0;
    tick(); tick(); smp();
    chk("t4_idle_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    chk("t4_stb_cyc",  32'(stb_cyc), 32'd1);
    chk("t4_ack_cnt",  32'(ack_cnt), 32'd1);

    // exception pending: no access
    stb_cyc = 0; ack_cnt = 0;
    tick(); op_mf = 1'b1; except = 1'b1; spr_adr = 32'h0000_0044;
    for (int k = 0; k < 4; k++) begin
      tick(); smp();
      chk("t5_stb", 32'(bus.spr_bus_stb_o), 32'd0);
    end
    tick(); op_mf = 1'b0; except = 1'b0;
    tick(); smp();
    chk("t5_ack_cnt", 32'(ack_cnt), 32'd0);

`ifdef PU_OR1K_SPR_TIMEOUT_EN
    // bus never acks: forced completion after 4 BUS cycles
    stb_cyc = 0; ack_cnt = 0;
    tick(); op_mf = 1'b1; spr_adr = 32'h0000_0055;
    exp_q.push_back('{mt: 1'b0, dat: 32'h0});
    for (int k = 0; k < 4; k++) begin
      tick(); smp();
      chk("t6_stb", 32'(bus.spr_bus_stb_o), 32'd1);
    end
    tick(); padv = 1'b1; smp();
    chk("t6_mfack", 32'(mf_ack), 32'd1);
    chk("t6_mfdat", mf_dat,      32'd0);
    chk("t6_tmo",   32'(tmo),    32'd1);
    tick(); op_mf = 1'b0; padv = 1'b0; smp();
    chk("t6_tmo_sticky", 32'(tmo), 32'd1);
    tick(); op_mt = 1'b1; spr_adr = 32'h0000_0066; rfb = 32'h1;
    exp_q.push_back('{mt: 1'b1, dat: 32'h0});
    tick(); bus.spr_bus_ack_i = 1'b1; smp();
    chk("t6_tmo_clr", 32'(tmo), 32'd0);
    tick(); bus.spr_bus_ack_i = 1'b0; padv = 1'b1; smp();
    chk("t6_mtack",   32'(mt_ack), 32'd1);
    tick(); op_mt = 1'b0; padv = 1'b0;
`else
    // bus never acks: BUS waits, no timeout, flush releases it
    stb_cyc = 0; ack_cnt = 0;
    tick(); op_mf = 1'b1; spr_adr = 32'h0000_0055;
    for (int k = 0; k < 8; k++) begin
      tick(); smp();
      chk("t6_stb_wait", 32'(bus.spr_bus_stb_o), 32'd1);
    end
    chk("t6_tmo", 32'(tmo), 32'd0);
    tick(); flush = 1'b1;
    tick(); flush = 1'b0; op_mf = 1'b0; smp();
    chk("t6_stb_drop", 32'(bus.spr_bus_stb_o), 32'd0);
    chk("t6_ack_cnt",  32'(ack_cnt), 32'd0);
`endif

    // reset mid-access aborts with no ack
    ack_cnt = 0;
    tick(); op_mt = 1'b1; spr_adr = 32'h0000_0077; rfb = 32'h77;
    tick(); smp();
    chk("t7_bus1", 32'(bus.spr_bus_stb_o), 32'd1);
    tick(); rst = 1'b1; smp();
    chk("t7_bus2", 32'(bus.spr_bus_stb_o), 32'd1);
    tick(); rst = 1'b0; op_mt = 1'b0; smp();
    chk("t7_stb_drop", 32'(bus.spr_bus_stb_o), 32'd0);
    chk("t7_adr_clr",  32'(bus.spr_bus_adr_o), 32'd0);
    tick(); tick(); smp();
    chk("t7_ack_cnt",  32'(ack_cnt), 32'd0);

    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
